// File: rtl/rc4_stream_core.sv
// rc4_stream_core: self-contained RC4 stream cipher engine.
// Key scheduling runs one KSA iteration per clock over a register-based S-box.
// The keystream is applied to a valid/ready byte stream with backpressure,
// and a new key can be loaded without reset.
// Build option: define RC4_DROP_EN to discard the first DROP_N keystream
// bytes after key scheduling (RC4-drop[n]). Without it, DROP_N is unused.

module rc4_stream_core #(
    parameter int KEY_MAX = 16,
    parameter int DROP_N  = 768
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         key_load,
    input  logic [$clog2(KEY_MAX+1)-1:0] key_len,
    input  logic [8*KEY_MAX-1:0]         key,
    output logic                         key_err,
    output logic                         busy,
    output logic                         key_ready,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [7:0]                   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   out_data
);

    localparam int KLW = $clog2(KEY_MAX + 1);
    localparam int KIW = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_INIT = 3'd1;
    localparam logic [2:0] ST_KSA  = 3'd2;
    localparam logic [2:0] ST_PRGA = 3'd4;
`ifdef RC4_DROP_EN
    localparam logic [2:0] ST_DROP = 3'd3;
    localparam int DCW = (DROP_N > 1) ? $clog2(DROP_N) : 1;
    logic [DCW-1:0] drop_cnt;
`endif

    logic [2:0]           state;
    logic [7:0]           i_idx;
    logic [7:0]           j_idx;
    logic [KIW-1:0]       kidx;
    logic [8*KEY_MAX-1:0] key_q;
    logic [KLW-1:0]       key_len_q;
    logic [255:0][7:0]    s_box;
    logic [255:0][7:0]    s_next;

    // Key-load qualification
    logic key_slot_open;
    logic key_len_ok;
    logic key_accept;
    logic key_reject;

    assign key_slot_open = (state == ST_IDLE) || (state == ST_PRGA);
    assign key_len_ok    = (key_len != '0) && (key_len <= KLW'(KEY_MAX));
    assign key_accept    = key_load && key_slot_open && key_len_ok;
    assign key_reject    = key_load && key_slot_open && !key_len_ok;

    // KSA datapath: j' = j + S[i] + key[i mod key_len]
    logic [7:0] ksa_si;
    logic [7:0] ksa_j;
    logic [7:0] ksa_sj;
    logic [7:0] key_byte;
    logic       key_last;

    assign key_byte = key_q[{kidx, 3'b000} +: 8];
    assign ksa_si   = s_box[i_idx];
    assign ksa_j    = j_idx + ksa_si + key_byte;
    assign ksa_sj   = s_box[ksa_j];
    assign key_last = (KLW'(kidx) + KLW'(1)) == key_len_q;

    // PRGA datapath: i' = i + 1, j' = j + S[i'], K read from the swapped S
    logic [7:0] pg_i;
    logic [7:0] pg_si;
    logic [7:0] pg_j;
    logic [7:0] pg_sj;
    logic [7:0] pg_t;
    logic [7:0] ks;

    assign pg_i  = i_idx + 8'd1;
    assign pg_si = s_box[pg_i];
    assign pg_j  = j_idx + pg_si;
    assign pg_sj = s_box[pg_j];
    assign pg_t  = pg_si + pg_sj;

    // Keystream byte: post-swap S[t], forwarding the two entries being swapped
    always_comb begin
        ks = s_box[pg_t];
        if (pg_t == pg_j) begin
            ks = pg_si;
        end else if (pg_t == pg_i) begin
            ks = pg_sj;
        end
    end

    // Stream handshake
    logic fire;
    logic prga_step;

    assign key_ready = (state == ST_PRGA);
    assign in_ready  = key_ready && (!out_valid || out_ready);
    assign fire      = in_valid && in_ready;
`ifdef RC4_DROP_EN
    assign busy      = (state == ST_INIT) || (state == ST_KSA) || (state == ST_DROP);
    assign prga_step = fire || (state == ST_DROP);
`else
    assign busy      = (state == ST_INIT) || (state == ST_KSA);
    assign prga_step = fire;
`endif

    // Swap port selection: KSA and PRGA each swap two entries per cycle
    logic       sw_en;
    logic [7:0] sw_a;
    logic [7:0] sw_da;
    logic [7:0] sw_b;
    logic [7:0] sw_db;

    always_comb begin
        sw_en = 1'b0;
        sw_a  = i_idx;
        sw_da = ksa_sj;
        sw_b  = ksa_j;
        sw_db = ksa_si;
        if (state == ST_KSA) begin
            sw_en = 1'b1;
        end else if (prga_step) begin
            sw_en = 1'b1;
            sw_a  = pg_i;
            sw_da = pg_sj;
            sw_b  = pg_j;
            sw_db = pg_si;
        end
    end

    // Next S-box contents: identity fill in INIT, otherwise a two-entry swap
    always_comb begin
        s_next = s_box;
        if (state == ST_INIT) begin
            for (int k = 0; k < 256; k++) begin
                s_next[k] = 8'(k);
            end
        end else if (sw_en) begin
            s_next[sw_a] = sw_da;
            s_next[sw_b] = sw_db;
        end
    end

    // S-box storage; contents are rebuilt in INIT so no reset is needed
    always_ff @(posedge clk) begin
        s_box <= s_next;
    end

    // Control FSM, index registers, key latch and output byte register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            i_idx     <= '0;
            j_idx     <= '0;
            kidx      <= '0;
            key_q     <= '0;
            key_len_q <= '0;
            key_err   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef RC4_DROP_EN
            drop_cnt  <= '0;
`endif
        end else begin
            key_err <= key_reject;
            if (key_accept) begin
                key_q     <= key;
                key_len_q <= key_len;
                out_valid <= 1'b0;
                state     <= ST_INIT;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    ST_INIT: begin
                        i_idx <= '0;
                        j_idx <= '0;
                        kidx  <= '0;
                        state <= ST_KSA;
                    end
                    ST_KSA: begin
                        kidx <= key_last ? '0 : kidx + KIW'(1);
                        if (i_idx == 8'd255) begin
                            i_idx <= '0;
                            j_idx <= '0;
`ifdef RC4_DROP_EN
                            drop_cnt <= '0;
                            state    <= ST_DROP;
`else
                            state <= ST_PRGA;
`endif
                        end else begin
                            i_idx <= i_idx + 8'd1;
                            j_idx <= ksa_j;
                        end
                    end
`ifdef RC4_DROP_EN
                    ST_DROP: begin
                        i_idx    <= pg_i;
                        j_idx    <= pg_j;
                        drop_cnt <= drop_cnt + DCW'(1);
                        if (drop_cnt == DCW'(DROP_N - 1)) begin
                            state <= ST_PRGA;
                        end
                    end
`endif
                    ST_PRGA: begin
                        if (fire) begin
                            i_idx     <= pg_i;
                            j_idx     <= pg_j;
                            out_valid <= 1'b1;
                            out_data  <= in_data ^ ks;
                        end else if (out_ready) begin
                            out_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rc4_stream_core.sv
// tb_rc4_stream_core: scoreboard bench for rc4_stream_core.
// Expected ciphertext is queued when a plaintext byte is accepted and popped
// when the core delivers an output byte. Define RC4_DROP_EN to run the
// drop[2] variant.

module tb_rc4_stream_core;

    localparam int KEY_MAX = 16;
    localparam int KLW     = $clog2(KEY_MAX + 1);
`ifdef RC4_DROP_EN
    localparam int KRDY_LAT = 259;
`else
    localparam int KRDY_LAT = 257;
`endif

    logic                 clk;
    logic                 rst;
    logic                 key_load;
    logic [KLW-1:0]       key_len;
    logic [8*KEY_MAX-1:0] key;
    logic                 key_err;
    logic                 busy;
    logic                 key_ready;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_data;

    rc4_stream_core #(
        .KEY_MAX(KEY_MAX),
        .DROP_N (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_load (key_load),
        .key_len  (key_len),
        .key      (key),
        .key_err  (key_err),
        .busy     (busy),
        .key_ready(key_ready),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pt_a[$];
    logic [7:0] ct_a[$];
    int         sent;
    int         stalls;
    bit         held_vld;
    logic [7:0] held_data;
    int         lat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8*KEY_MAX-1:0] mk_key(input string s);
        logic [8*KEY_MAX-1:0] k;
        k = '0;
        for (int n = 0; n < s.len() && n < KEY_MAX; n++) begin
            k[8*n +: 8] = s[n];
        end
        return k;
    endfunction

    task automatic load_pt(input string s);
        pt_a.delete();
        for (int n = 0; n < s.len(); n++) begin
            pt_a.push_back(s[n]);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_key_err"},   key_err,   0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_key_ready"}, key_ready, 0);
        chk({tag, "_in_ready"},  in_ready,  0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"},  out_data,  0);
    endtask

    // Load a key and measure cycles from the sampling edge to key_ready
    task automatic load_key(input string ks, input int len, output int l);
        key_load = 1'b1;
        key_len  = KLW'(len);
        key      = mk_key(ks);
        @(posedge clk); #1;
        key_load = 1'b0;
        chk("busy_after_load", busy, 1);
        l = 0;
        while (!key_ready && l < 3000) begin
            @(posedge clk); #1;
            l++;
        end
        chk("busy_in_prga", busy, 0);
    endtask

    // One clock of the stream: observe at negedge, advance past posedge
    task automatic step();
        @(negedge clk);
        if (held_vld) begin
            chk("hold_data", out_data, held_data);
            chk("hold_valid", out_valid, 1);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("extra_out", exp_q.size(), 1);
            else chk("out_byte", out_data, exp_q.pop_front());
        end
        held_vld  = out_valid && !out_ready;
        held_data = out_data;
        if (in_valid && !in_ready) stalls++;
        if (in_valid && in_ready) begin
            exp_q.push_back(ct_a[sent]);
            sent++;
        end
        @(posedge clk); #1;
    endtask

    task automatic run_stream(input bit bp);
        int cyc;
        exp_q.delete();
        sent     = 0;
        stalls   = 0;
        held_vld = 1'b0;
        cyc      = 0;
        in_valid  = (pt_a.size() > 0);
        in_data   = pt_a[0];
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        while ((sent < pt_a.size() || exp_q.size() != 0) && cyc < 1000) begin
            step();
            cyc++;
            if (sent < pt_a.size()) begin
                in_valid = 1'b1;
                in_data  = pt_a[sent];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'h00;
            end
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        chk("stream_sent", sent, pt_a.size());
        chk("stream_drain", exp_q.size(), 0);
        if (!bp) begin
            chk("stream_stalls", stalls, 0);
            chk("stream_cycles", cyc, pt_a.size() + 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        key_load  = 1'b0;
        key_len   = '0;
        key       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

`ifndef RC4_DROP_EN
        // Key "Key", plaintext "Plaintext", full throughput
        load_key("Key", 3, lat);
        chk("krdy_lat_key", lat, KRDY_LAT);
        load_pt("Plaintext");
        ct_a = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        run_stream(1'b0);

        // Rekey in PRGA: "Wiki" / "pedia", then "Secret" / "Attack at dawn"
        load_key("Wiki", 4, lat);
        chk("krdy_lat_wiki", lat, KRDY_LAT);
        load_pt("pedia");
        ct_a = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
        run_stream(1'b0);
        load_key("Secret", 6, lat);
        load_pt("Attack at dawn");
        ct_a = '{8'h45, 8'hA0, 8'h1F, 8'h64, 8'h5F, 8'hC3, 8'h5B,
                 8'h38, 8'h35, 8'h52, 8'h54, 8'h4B, 8'h9B, 8'hF5};
        run_stream(1'b0);

        // Backpressure: zeros expose the raw keystream of "Key"
        load_key("Key", 3, lat);
        pt_a.delete();
        for (int n = 0; n < 10; n++) pt_a.push_back(8'h00);
        ct_a = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        run_stream(1'b1);
`else
        // drop[2]: first two keystream bytes of "Key" are discarded
        load_key("Key", 3, lat);
        chk("krdy_lat_drop", lat, KRDY_LAT);
        pt_a = '{8'h00, 8'h00};
        ct_a = '{8'h77, 8'h81};
        run_stream(1'b0);
`endif

        // Bad key lengths in PRGA: one key_err pulse each, stream stays up
        key_load = 1'b1;
        key_len  = '0;
        @(posedge clk); #1;
        key_load = 1'b0;
        chk("kerr_len0_pulse", key_err, 1);
        chk("kerr_len0_ready", key_ready, 1);
        @(posedge clk); #1;
        chk("kerr_len0_clear", key_err, 0);
        key_load = 1'b1;
        key_len  = KLW'(KEY_MAX + 1);
        @(posedge clk); #1;
        key_load = 1'b0;
        chk("kerr_lenmax_pulse", key_err, 1);
        chk("kerr_lenmax_ready", key_ready, 1);
        chk("kerr_lenmax_busy", busy, 0);
        @(posedge clk); #1;
        chk("kerr_lenmax_clear", key_err, 0);

`ifndef RC4_DROP_EN
        // key_load during KSA is ignored, valid or not
        key_load = 1'b1;
        key_len  = KLW'(3);
        key      = mk_key("Key");
        @(posedge clk); #1;
        key_load = 1'b0;
        lat = 0;
        repeat (50) begin
            @(posedge clk); #1;
            lat++;
        end
        key_load = 1'b1;
        key_len  = KLW'(4);
        key      = mk_key("Wiki");
        @(posedge clk); #1;
        lat++;
        key_load = 1'b0;
        chk("ksa_ignore_err", key_err, 0);
        chk("ksa_ignore_busy", busy, 1);
        key_load = 1'b1;
        key_len  = '0;
        @(posedge clk); #1;
        lat++;
        key_load = 1'b0;
        chk("ksa_badlen_err", key_err, 0);
        while (!key_ready && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ksa_ignore_lat", lat, KRDY_LAT);
        load_pt("Plaintext");
        ct_a = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        run_stream(1'b0);

        // Reset in the middle of KSA, then a fresh key
        key_load = 1'b1;
        key_len  = KLW'(4);
        key      = mk_key("Wiki");
        @(posedge clk); #1;
        key_load = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_outputs("midksa_rst");
        load_key("Key", 3, lat);
        chk("krdy_lat_after_rst", lat, KRDY_LAT);
        load_pt("Plaintext");
        ct_a = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        run_stream(1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
